regfile_access_arbiter: RTL and testbench

//  Owns the single write port and the rs2 read port of the 31-entry integer register file (x1..x31; x0 hardwired 0).

---
 rtl/regfile_access_arbiter_pkg.sv | 19 +
 rtl/regfile_access_arbiter.sv | 129 ++++++++++++
 tb/tb_regfile_access_arbiter.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_access_arbiter_pkg.sv
// Shared types for the register file access arbiter.
// Index width, register count and the arbiter state encoding.
package regfile_access_arbiter_pkg;

  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS  = 32;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  function automatic logic is_x0(
    input logic [REG_IDX_W-1:0] idx
  );
    return idx == '0;
  endfunction

endpackage

// File: rtl/regfile_access_arbiter.sv
// Register file write/rs2 port owner: post-reset zero-fill,
// then core-first arbitration against debug accesses.
module regfile_access_arbiter
  import regfile_access_arbiter_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic                 busy,
  input  logic                 core_halted,
  input  logic                 core_we,
  input  logic [REG_IDX_W-1:0] core_rd,
  input  logic [XLEN-1:0]      core_wdata,
  input  logic [REG_IDX_W-1:0] core_rs1_idx,
  input  logic [REG_IDX_W-1:0] core_rs2_idx,
  output logic [XLEN-1:0]      core_rs1,
  output logic [XLEN-1:0]      core_rs2,
  input  logic                 dbg_req_valid,
  output logic                 dbg_req_ready,
  input  logic                 dbg_req_write,
  input  logic [REG_IDX_W-1:0] dbg_req_addr,
  input  logic [XLEN-1:0]      dbg_req_wdata,
  output logic                 dbg_rsp_valid,
  input  logic                 dbg_rsp_ready,
  output logic [XLEN-1:0]      dbg_rsp_rdata,
  output logic [REG_IDX_W-1:0] rf_reg_w,
  output logic [REG_IDX_W-1:0] rf_reg_1,
  output logic [REG_IDX_W-1:0] rf_reg_2,
  output logic                 rf_write,
  output logic [XLEN-1:0]      rf_wdata,
  input  logic [XLEN-1:0]      rf_rs1,
  input  logic [XLEN-1:0]      rf_rs2
);

  localparam state_e RESET_STATE =
    CLEAR_ON_RESET ? CLEAR : RUN;
  localparam logic [REG_IDX_W-1:0] LAST_IDX =
    REG_IDX_W'(NUM_REGS - 1);

  state_e               state_q, state_d;
  logic [REG_IDX_W-1:0] clear_idx_q, clear_idx_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0]      rsp_rdata_q, rsp_rdata_d;
  logic                 run;
  logic                 accept;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= RESET_STATE;
      clear_idx_q <= REG_IDX_W'(1);
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      clear_idx_q <= clear_idx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clear_idx_d = clear_idx_q;
    if (state_q == CLEAR) begin
      clear_idx_d = clear_idx_q + REG_IDX_W'(1);
      if (clear_idx_q == LAST_IDX) begin
        state_d = RUN;
      end
    end
  end

  assign run           = state_q == RUN;
  assign dbg_req_ready = run & core_halted
                       & ~core_we & ~rsp_valid_q;
  assign accept        = dbg_req_valid & dbg_req_ready;

  // A pending response blocks accepts, so the two never collide.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      if (dbg_req_write || is_x0(dbg_req_addr)) begin
        rsp_rdata_d = '0;
      end else begin
        rsp_rdata_d = rf_rs2;
      end
    end else if (rsp_valid_q && dbg_rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_comb begin
    busy     = 1'b0;
    rf_write = 1'b0;
    rf_reg_w = core_rd;
    rf_wdata = core_wdata;
    rf_reg_2 = core_rs2_idx;
    unique case (1'b1)
      !run: begin
        busy     = 1'b1;
        rf_write = 1'b1;
        rf_reg_w = clear_idx_q;
        rf_wdata = '0;
      end
      run && core_we: begin
        rf_write = !is_x0(core_rd);
      end
      accept && dbg_req_write: begin
        rf_write = !is_x0(dbg_req_addr);
        rf_reg_w = dbg_req_addr;
        rf_wdata = dbg_req_wdata;
      end
      accept && !dbg_req_write: begin
        rf_reg_2 = dbg_req_addr;
      end
      default: ;
    endcase
  end

  assign rf_reg_1      = core_rs1_idx;
  assign core_rs1      = rf_rs1;
  assign core_rs2      = rf_rs2;
  assign dbg_rsp_valid = rsp_valid_q;
  assign dbg_rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Bench for regfile_access_arbiter: register file model,
// cycle-level reference model and directed scenarios.
module tb_regfile_access_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        busy;
  logic        core_halted = 1'b0;
  logic        core_we = 1'b0;
  logic [4:0]  core_rd = '0;
  logic [31:0] core_wdata = '0;
  logic [4:0]  core_rs1_idx = '0;
  logic [4:0]  core_rs2_idx = '0;
  logic [31:0] core_rs1;
  logic [31:0] core_rs2;
  logic        dbg_req_valid = 1'b0;
  logic        dbg_req_ready;
  logic        dbg_req_write = 1'b0;
  logic [4:0]  dbg_req_addr = '0;
  logic [31:0] dbg_req_wdata = '0;
  logic        dbg_rsp_valid;
  logic        dbg_rsp_ready = 1'b0;
  logic [31:0] dbg_rsp_rdata;
  logic [4:0]  rf_reg_w;
  logic [4:0]  rf_reg_1;
  logic [4:0]  rf_reg_2;
  logic        rf_write;
  logic [31:0] rf_wdata;
  logic [31:0] rf_rs1;
  logic [31:0] rf_rs2;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  regfile_access_arbiter #(
    .XLEN(32),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .busy(busy),
    .core_halted(core_halted),
    .core_we(core_we),
    .core_rd(core_rd),
    .core_wdata(core_wdata),
    .core_rs1_idx(core_rs1_idx),
    .core_rs2_idx(core_rs2_idx),
    .core_rs1(core_rs1),
    .core_rs2(core_rs2),
    .dbg_req_valid(dbg_req_valid),
    .dbg_req_ready(dbg_req_ready),
    .dbg_req_write(dbg_req_write),
    .dbg_req_addr(dbg_req_addr),
    .dbg_req_wdata(dbg_req_wdata),
    .dbg_rsp_valid(dbg_rsp_valid),
    .dbg_rsp_ready(dbg_rsp_ready),
    .dbg_rsp_rdata(dbg_rsp_rdata),
    .rf_reg_w(rf_reg_w),
    .rf_reg_1(rf_reg_1),
    .rf_reg_2(rf_reg_2),
    .rf_write(rf_write),
    .rf_wdata(rf_wdata),
    .rf_rs1(rf_rs1),
    .rf_rs2(rf_rs2)
  );

  // Storage without reset: seeded with junk so the fill matters.
  logic [31:0] mem [32];
  bit          seeded = 1'b0;

  always @(posedge clock) begin
    if (!seeded) begin
      for (int i = 0; i < 32; i++) begin
        mem[i] <= 32'hBAD0_0000 + i;
      end
      seeded <= 1'b1;
    end else if (rf_write) begin
      mem[rf_reg_w] <= rf_wdata;
    end
  end

  assign rf_rs1 = (rf_reg_1 == 0) ? 32'h0 : mem[rf_reg_1];
  assign rf_rs2 = (rf_reg_2 == 0) ? 32'h0 : mem[rf_reg_2];

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h",
               nm, act, exp);
    end
  endtask

  // Reference model: architectural registers, fill count,
  // and one outstanding debug response.
  logic [31:0] regs [32];
  int          clr_cnt = 0;
  bit          known = 1'b0;
  bit          pend = 1'b0;
  logic [31:0] pend_data = '0;

  always @(negedge clock) begin
    bit          exp_we;
    bit          exp_rdy;
    bit          acc;
    logic [4:0]  ew;
    logic [31:0] ewd;
    logic [4:0]  er2;
    if (!reset) begin
      clr_cnt = 0;
      known   = 1'b0;
      pend    = 1'b0;
      regs[0] = 32'h0;
      chk("m_rst_busy", 32'(busy), 1);
      chk("m_rst_ready", 32'(dbg_req_ready), 0);
      chk("m_rst_rspv", 32'(dbg_rsp_valid), 0);
      chk("m_rst_rdata", dbg_rsp_rdata, 0);
    end else begin
      chk("m_rsp_valid", 32'(dbg_rsp_valid),
          32'(pend));
      if (pend) chk("m_rsp_rdata", dbg_rsp_rdata,
                    pend_data);
      if (clr_cnt < 31) begin
        chk("m_clr_busy", 32'(busy), 1);
        chk("m_clr_ready", 32'(dbg_req_ready), 0);
        chk("m_clr_we", 32'(rf_write), 1);
        chk("m_clr_idx", 32'(rf_reg_w), clr_cnt + 1);
        chk("m_clr_wd", rf_wdata, 0);
        regs[clr_cnt + 1] = 32'h0;
        clr_cnt++;
        if (clr_cnt == 31) known = 1'b1;
      end else begin
        exp_rdy = core_halted && !core_we && !pend;
        acc     = dbg_req_valid && exp_rdy;
        exp_we  = 1'b0;
        ew      = core_rd;
        ewd     = core_wdata;
        er2     = core_rs2_idx;
        if (core_we) begin
          exp_we = core_rd != 0;
        end else if (acc && dbg_req_write) begin
          exp_we = dbg_req_addr != 0;
          ew     = dbg_req_addr;
          ewd    = dbg_req_wdata;
        end else if (acc) begin
          er2 = dbg_req_addr;
        end
        chk("m_busy", 32'(busy), 0);
        chk("m_ready", 32'(dbg_req_ready),
            32'(exp_rdy));
        chk("m_we", 32'(rf_write), 32'(exp_we));
        if (exp_we) begin
          chk("m_wi", 32'(rf_reg_w), 32'(ew));
          chk("m_wd", rf_wdata, ewd);
        end
        chk("m_reg2", 32'(rf_reg_2), 32'(er2));
        if (known) begin
          chk("m_rs1", core_rs1, regs[core_rs1_idx]);
          chk("m_rs2", core_rs2, regs[er2]);
        end
        if (pend && dbg_rsp_ready) pend = 1'b0;
        if (acc) begin
          pend      = 1'b1;
          pend_data = dbg_req_write ? 32'h0
                                    : regs[dbg_req_addr];
        end
        if (exp_we) regs[ew] = ewd;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic count_clear(
    output int cnt,
    output int first,
    output int last
  );
    cnt   = 0;
    first = -1;
    last  = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (!busy) break;
      if (rf_write) begin
        if (cnt == 0) first = int'(rf_reg_w);
        last = int'(rf_reg_w);
        cnt++;
      end
    end
  endtask

  task automatic dbg_xfer(
    input  bit          wr,
    input  logic [4:0]  a,
    input  logic [31:0] wd,
    output logic [31:0] rd
  );
    int n;
    dbg_req_valid = 1'b1;
    dbg_req_write = wr;
    dbg_req_addr  = a;
    dbg_req_wdata = wd;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!dbg_req_ready && n < 50);
    if (!dbg_req_ready) chk("dbg_accept_timeout", 0, 1);
    step();
    dbg_req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!dbg_rsp_valid && n < 50);
    if (!dbg_rsp_valid) chk("dbg_rsp_timeout", 0, 1);
    rd = dbg_rsp_rdata;
    dbg_rsp_ready = 1'b1;
    step();
    dbg_rsp_ready = 1'b0;
  endtask

  initial begin
    int          cnt;
    int          first;
    int          last;
    bit          allz;
    logic [31:0] rd;

    // Reset and zero-fill
    step();
    step();
    @(negedge clock);
    chk("rst_busy", 32'(busy), 1);
    chk("rst_ready", 32'(dbg_req_ready), 0);
    step();
    reset = 1'b1;
    count_clear(cnt, first, last);
    chk("fill_cycles", cnt, 31);
    chk("fill_first", first, 1);
    chk("fill_last", last, 31);
    allz = 1'b1;
    for (int i = 1; i < 32; i++) begin
      if (mem[i] !== 32'h0) allz = 1'b0;
    end
    chk("fill_all_zero", 32'(allz), 1);

    // Core write then read back
    step();
    core_we    = 1'b1;
    core_rd    = 5'd5;
    core_wdata = 32'hDEADBEEF;
    step();
    core_we      = 1'b0;
    core_rs1_idx = 5'd5;
    @(negedge clock);
    chk("core_rd_x5", core_rs1, 32'hDEADBEEF);

    // Debug read x5, response held until ready
    step();
    core_halted   = 1'b1;
    dbg_req_valid = 1'b1;
    dbg_req_write = 1'b0;
    dbg_req_addr  = 5'd5;
    @(negedge clock);
    chk("dbg_rd_ready", 32'(dbg_req_ready), 1);
    step();
    dbg_req_valid = 1'b0;
    @(negedge clock);
    chk("dbg_rd_valid", 32'(dbg_rsp_valid), 1);
    chk("dbg_rd_data", dbg_rsp_rdata, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clock);
      chk("dbg_rd_hold", 32'(dbg_rsp_valid), 1);
    end
    step();
    dbg_rsp_ready = 1'b1;
    step();
    dbg_rsp_ready = 1'b0;
    @(negedge clock);
    chk("dbg_rd_drop", 32'(dbg_rsp_valid), 0);

    // Debug write x0 suppressed, read x0 returns 0
    step();
    dbg_req_valid = 1'b1;
    dbg_req_write = 1'b1;
    dbg_req_addr  = 5'd0;
    dbg_req_wdata = 32'h1234;
    @(negedge clock);
    chk("dbg_wr_x0_we", 32'(rf_write), 0);
    step();
    dbg_req_valid = 1'b0;
    @(negedge clock);
    chk("dbg_wr_ack", dbg_rsp_rdata, 0);
    step();
    dbg_rsp_ready = 1'b1;
    step();
    dbg_rsp_ready = 1'b0;
    dbg_xfer(1'b0, 5'd0, 32'h0, rd);
    chk("dbg_rd_x0", rd, 0);

    // Core write wins over a same-cycle debug write
    core_we       = 1'b1;
    core_rd       = 5'd7;
    core_wdata    = 32'h77;
    dbg_req_valid = 1'b1;
    dbg_req_write = 1'b1;
    dbg_req_addr  = 5'd7;
    dbg_req_wdata = 32'h99;
    @(negedge clock);
    chk("arb_ready_lo", 32'(dbg_req_ready), 0);
    chk("arb_core_wd", rf_wdata, 32'h77);
    step();
    core_we = 1'b0;
    @(negedge clock);
    chk("arb_ready_hi", 32'(dbg_req_ready), 1);
    chk("arb_dbg_wd", rf_wdata, 32'h99);
    step();
    dbg_req_valid = 1'b0;
    dbg_rsp_ready = 1'b1;
    core_rs1_idx  = 5'd7;
    step();
    dbg_rsp_ready = 1'b0;
    @(negedge clock);
    chk("arb_x7", core_rs1, 32'h99);

    // Not halted: request waits; halt drop keeps response
    step();
    core_halted   = 1'b0;
    dbg_req_valid = 1'b1;
    dbg_req_write = 1'b0;
    dbg_req_addr  = 5'd5;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("unhalt_wait", 32'(dbg_req_ready), 0);
      step();
    end
    core_halted = 1'b1;
    step();
    dbg_req_valid = 1'b0;
    core_halted   = 1'b0;
    @(negedge clock);
    chk("unhalt_pend", 32'(dbg_rsp_valid), 1);
    step();
    @(negedge clock);
    chk("unhalt_data", dbg_rsp_rdata, 32'hDEADBEEF);
    dbg_rsp_ready = 1'b1;
    step();
    dbg_rsp_ready = 1'b0;
    core_halted   = 1'b1;

    // Reset drops a pending response and restarts the fill
    dbg_req_valid = 1'b1;
    dbg_req_write = 1'b0;
    dbg_req_addr  = 5'd7;
    step();
    dbg_req_valid = 1'b0;
    @(negedge clock);
    chk("rst_pend_set", 32'(dbg_rsp_valid), 1);
    step();
    reset = 1'b0;
    #1;
    chk("rst_pend_lost", 32'(dbg_rsp_valid), 0);
    chk("rst_busy_async", 32'(busy), 1);
    step();
    reset = 1'b1;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      cnt++;
      if (busy && rf_reg_w == 5'd12) break;
    end
    chk("mid_reach_12", 32'(rf_reg_w), 12);
    step();
    reset = 1'b0;
    #1;
    chk("mid_busy", 32'(busy), 1);
    chk("mid_idx1", 32'(rf_reg_w), 1);
    step();
    reset = 1'b1;
    count_clear(cnt, first, last);
    chk("refill_cycles", cnt, 31);
    chk("refill_first", first, 1);
    chk("refill_last", last, 31);

    // Short run after refill, checked by the model
    core_halted = 1'b0;
    for (int i = 1; i < 6; i++) begin
      step();
      core_we      = 1'b1;
      core_rd      = 5'(i * 3);
      core_wdata   = 32'h1000 * i;
      core_rs1_idx = 5'((i - 1) * 3);
      core_rs2_idx = 5'(i);
    end
    step();
    core_we      = 1'b0;
    core_rs1_idx = 5'd15;
    @(negedge clock);
    chk("run_x15", core_rs1, 32'h5000);
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
